// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register.
// Captures the ID control bundle, operands, immediates, register addresses
// and status flags, and presents them to EXE one cycle later. Supports
// freeze (stall), flush (taken branch) and bubble (hazard NOP) with priority
// rst > flush > freeze > bubble > load, and tracks a valid bit per slot.
// Optional: define ID_EXE_PERF_CNT_EN to add bubble/flush/freeze event counters.
module id_exe_stage_reg #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              bubble,
  input  logic [8:0]        ctrl_in,
  input  logic [WIDTH-1:0]  pc_in,
  input  logic [WIDTH-1:0]  val_rn_in,
  input  logic [WIDTH-1:0]  val_rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [REG_AW-1:0] src1_in,
  input  logic [REG_AW-1:0] src2_in,
  input  logic [3:0]        sr_in,
  output logic [8:0]        ctrl_out,
  output logic [WIDTH-1:0]  pc_out,
  output logic [WIDTH-1:0]  val_rn_out,
  output logic [WIDTH-1:0]  val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [REG_AW-1:0] dest_out,
  output logic [REG_AW-1:0] src1_out,
  output logic [REG_AW-1:0] src2_out,
  output logic [3:0]        sr_out,
  output logic              valid_out
`ifdef ID_EXE_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       freeze_cnt
`endif
);

  logic [8:0]        r_ctrl;
  logic              r_valid;
  logic [WIDTH-1:0]  r_pc;
  logic [WIDTH-1:0]  r_val_rn;
  logic [WIDTH-1:0]  r_val_rm;
  logic              r_imm;
  logic [11:0]       r_shift_operand;
  logic [23:0]       r_signed_imm_24;
  logic [REG_AW-1:0] r_dest;
  logic [REG_AW-1:0] r_src1;
  logic [REG_AW-1:0] r_src2;
  logic [3:0]        r_sr;

  // Control bundle and valid bit: flush and bubble both leave an empty slot
  // with all control cleared, so an invalid slot never carries WB/MEM/B/S.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_ctrl  <= 9'b0;
      r_valid <= 1'b0;
    end else if (!freeze) begin
      if (bubble) begin
        r_ctrl  <= 9'b0;
        r_valid <= 1'b0;
      end else begin
        r_ctrl  <= ctrl_in;
        r_valid <= 1'b1;
      end
    end
  end

  // Data fields: cleared on reset/flush, held on freeze, otherwise loaded
  // (including under a bubble, so PC and friends keep tracking ID for debug).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_pc            <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_imm           <= 1'b0;
      r_shift_operand <= 12'b0;
      r_signed_imm_24 <= 24'b0;
      r_dest          <= '0;
      r_src1          <= '0;
      r_src2          <= '0;
      r_sr            <= 4'b0;
    end else if (!freeze) begin
      r_pc            <= pc_in;
      r_val_rn        <= val_rn_in;
      r_val_rm        <= val_rm_in;
      r_imm           <= imm_in;
      r_shift_operand <= shift_operand_in;
      r_signed_imm_24 <= signed_imm_24_in;
      r_dest          <= dest_in;
      r_src1          <= src1_in;
      r_src2          <= src2_in;
      r_sr            <= sr_in;
    end
  end

  // S is additionally gated by valid so a dead slot can never update flags.
  assign ctrl_out          = {r_ctrl[8:1], r_ctrl[0] & r_valid};
  assign valid_out         = r_valid;
  assign pc_out            = r_pc;
  assign val_rn_out        = r_val_rn;
  assign val_rm_out        = r_val_rm;
  assign imm_out           = r_imm;
  assign shift_operand_out = r_shift_operand;
  assign signed_imm_24_out = r_signed_imm_24;
  assign dest_out          = r_dest;
  assign src1_out          = r_src1;
  assign src2_out          = r_src2;
  assign sr_out            = r_sr;

`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_freeze_cnt;
  logic        w_flush_win;
  logic        w_freeze_win;
  logic        w_bubble_win;

  assign w_flush_win  = flush;
  assign w_freeze_win = !flush && freeze;
  assign w_bubble_win = !flush && !freeze && bubble;

  // Event counters: each counts edges where its condition won arbitration;
  // they wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= 32'd0;
      r_flush_cnt  <= 32'd0;
      r_freeze_cnt <= 32'd0;
    end else begin
      if (w_bubble_win) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_flush_win)  r_flush_cnt  <= r_flush_cnt + 32'd1;
      if (w_freeze_win) r_freeze_cnt <= r_freeze_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign freeze_cnt = r_freeze_cnt;
`endif

endmodule
